// File: rtl/cp0_nested.sv
// cp0_nested: coprocessor-0 for the 54-instruction MIPS core.
// Holds Status, Cause and EPC, plus a hardware EPC/IE stack so that
// exceptions and interrupts can nest up to NEST_DEPTH levels. Produces a
// registered one-cycle redirect pulse (o_exc_take/o_exc_pc) for the PC mux.
// Optional feature macro: CP0_TIMER_EN adds Count (reg 9) and Compare
// (reg 11); timer-pending drives IP[7].
module cp0_nested #(
  parameter int          NUM_IRQ    = 6,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mfc0,
  input  logic               i_mtc0,
  input  logic [4:0]         i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  input  logic               i_exception,
  input  logic [4:0]         i_cause,
  input  logic               i_eret,
  input  logic [31:0]        i_pc,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic [31:0]        o_status,
  output logic               o_exc_take,
  output logic [31:0]        o_exc_pc,
  output logic [3:0]         o_depth,
  output logic               o_nest_overflow
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [3:0] DEPTH_MAX    = 4'(NEST_DEPTH);

  // architectural state
  logic        r_ie;
  logic [7:0]  r_im;
  logic [4:0]  r_exccode;
  logic [7:0]  r_ip;
  logic [3:0]  r_depth;
  logic        r_ovf;
  logic        r_take;
  logic [31:0] r_exc_pc;

  // EPC / saved-IE stack; entry 0 is the outermost level
  logic [31:0]           r_epc [NEST_DEPTH];
  logic [NEST_DEPTH-1:0] r_sie;

  // decoded per-cycle control
  logic [7:0]  w_irq_ext;
  logic [7:0]  w_ip_next;
  logic        w_int_req;
  logic        w_entry;
  logic        w_do_eret;
  logic        w_do_mtc0;
  logic        w_full;
  logic [2:0]  w_top_idx;
  logic [2:0]  w_push_idx;
  logic [31:0] w_top_epc;
  logic        w_top_sie;
  logic        w_epc_we;
  logic [2:0]  w_epc_widx;
  logic [31:0] w_epc_wdata;
  logic        w_sie_we;
  logic [31:0] w_status;
  logic [31:0] w_cause;

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tpend;
`endif

  // widen the external irq lines onto the 8-bit IP field
  always_comb begin
    w_irq_ext = 8'h00;
    w_irq_ext[NUM_IRQ-1:0] = i_irq;
  end

`ifdef CP0_TIMER_EN
  // timer-pending joins irq[7] in the same sampling stage
  always_comb begin
    w_ip_next    = w_irq_ext;
    w_ip_next[7] = w_irq_ext[7] | r_tpend;
  end
`else
  // without the timer IP[7] comes only from the irq lines
  always_comb begin
    w_ip_next = w_irq_ext;
  end
`endif

  // event arbitration: exception > interrupt > eret > mtc0
  always_comb begin
    w_int_req  = r_ie & (|(r_ip & r_im));
    w_entry    = i_exception | w_int_req;
    w_do_eret  = (~w_entry) & i_eret;
    w_do_mtc0  = (~w_entry) & (~i_eret) & i_mtc0;
    w_full     = (r_depth == DEPTH_MAX);
    w_push_idx = r_depth[2:0];
    if (r_depth == 4'd0) begin
      w_top_idx = 3'd0;
    end else begin
      w_top_idx = 3'(r_depth - 4'd1);
    end
  end

  // top-of-stack read mux (entry 0 when the stack is empty)
  always_comb begin
    w_top_epc = 32'h0000_0000;
    w_top_sie = 1'b0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      w_top_epc = (w_top_idx == 3'(i)) ? r_epc[i] : w_top_epc;
      w_top_sie = (w_top_idx == 3'(i)) ? r_sie[i] : w_top_sie;
    end
  end

  // stack write control: push on entry, overwrite top on overflow or MTC0 EPC
  always_comb begin
    w_epc_we    = 1'b0;
    w_epc_widx  = w_top_idx;
    w_epc_wdata = i_pc;
    w_sie_we    = 1'b0;
    if (w_entry) begin
      w_epc_we = 1'b1;
      if (!w_full) begin
        w_epc_widx = w_push_idx;
        w_sie_we   = 1'b1;
      end else begin
        w_epc_widx = w_top_idx;
      end
    end else if (w_do_mtc0 && (i_addr == ADDR_EPC)) begin
      w_epc_we    = 1'b1;
      w_epc_wdata = i_wdata;
    end else begin
      w_epc_we = 1'b0;
    end
  end

  // visible register images
  always_comb begin
    w_status = {16'h0000, r_im, 6'b000000, (r_depth != 4'd0), r_ie};
    w_cause  = {16'h0000, r_ip, 1'b0, r_exccode, 2'b00};
  end

  // MFC0 read port: zero unless strobed and mapped
  always_comb begin
    o_rdata = 32'h0000_0000;
    if (i_mfc0) begin
      case (i_addr)
        ADDR_STATUS:  o_rdata = w_status;
        ADDR_CAUSE:   o_rdata = w_cause;
        ADDR_EPC:     o_rdata = w_top_epc;
`ifdef CP0_TIMER_EN
        ADDR_COUNT:   o_rdata = r_count;
        ADDR_COMPARE: o_rdata = r_compare;
`endif
        default:      o_rdata = 32'h0000_0000;
      endcase
    end else begin
      o_rdata = 32'h0000_0000;
    end
  end

  // EPC and saved-IE stack storage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        r_epc[i] <= 32'h0000_0000;
      end
      r_sie <= '0;
    end else begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (w_epc_we && (w_epc_widx == 3'(i))) begin
          r_epc[i] <= w_epc_wdata;
        end
        if (w_sie_we && (w_epc_widx == 3'(i))) begin
          r_sie[i] <= r_ie;
        end
      end
    end
  end

  // Status/Cause/depth state and the registered redirect pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ie      <= 1'b0;
      r_im      <= 8'h00;
      r_exccode <= 5'b00000;
      r_ip      <= 8'h00;
      r_depth   <= 4'd0;
      r_ovf     <= 1'b0;
      r_take    <= 1'b0;
      r_exc_pc  <= 32'h0000_0000;
    end else begin
      r_ip   <= w_ip_next;
      r_take <= w_entry | w_do_eret;
      if (w_entry) begin
        r_exc_pc <= EXC_VECTOR;
      end else if (w_do_eret) begin
        r_exc_pc <= w_top_epc;
      end else begin
        r_exc_pc <= 32'h0000_0000;
      end

      if (w_entry) begin
        r_ie      <= 1'b0;
        r_exccode <= i_exception ? i_cause : 5'b00000;
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_depth <= r_depth + 4'd1;
        end
      end else if (w_do_eret) begin
        // at depth 0 an ERET only redirects; IE and depth stay put
        if (r_depth != 4'd0) begin
          r_ie    <= w_top_sie;
          r_depth <= r_depth - 4'd1;
        end
      end else if (w_do_mtc0 && (i_addr == ADDR_STATUS)) begin
        r_ie <= i_wdata[0];
        r_im <= i_wdata[15:8];
      end
    end
  end

`ifdef CP0_TIMER_EN
  // free-running Count, Compare and the sticky timer-pending flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= 32'h0000_0000;
      r_compare <= 32'h0000_0000;
      r_tpend   <= 1'b0;
    end else begin
      if (w_do_mtc0 && (i_addr == ADDR_COUNT)) begin
        r_count <= i_wdata;
      end else begin
        r_count <= r_count + 32'd1;
      end
      if (w_do_mtc0 && (i_addr == ADDR_COMPARE)) begin
        r_compare <= i_wdata;
        r_tpend   <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'h0000_0000)) begin
        r_tpend <= 1'b1;
      end
    end
  end
`endif

  assign o_status        = w_status;
  assign o_exc_take      = r_take;
  assign o_exc_pc        = r_exc_pc;
  assign o_depth         = r_depth;
  assign o_nest_overflow = r_ovf;

endmodule

// File: doc/cp0_nested.md
Name: cp0_nested

Overview:
- Parametrised coprocessor-0 for the 54-instruction MIPS core.
- Holds Status, Cause and EPC, plus a hardware EPC/IE stack for nested exceptions.
- Latches and masks up to 8 external interrupt lines.
- Produces a registered redirect pulse with its target PC, which the core's PC mux uses for exception entry and ERET.

Parameters:
- NUM_IRQ, 6: external interrupt lines (1..8), mapped to Cause.IP[NUM_IRQ-1:0] = Cause[8+NUM_IRQ-1:8].
- NEST_DEPTH, 4: EPC/IE stack entries (1..8).
- EXC_VECTOR, 32'h0000_4180: handler entry address.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- mfc0  in  1  read strobe
- mtc0  in  1  write strobe
- addr  in  5  CP0 register number
- wdata  in  32  MTC0 data
- rdata  out  32  MFC0 data
- exception  in  1  synchronous exception request (syscall/break/teq)
- cause  in  5  ExcCode for exception
- eret  in  1  return request
- pc  in  32  PC of faulting/interrupted instruction
- irq  in  NUM_IRQ  level interrupt requests
- status  out  32  current Status value
- exc_take  out  1  one-cycle redirect pulse
- exc_pc  out  32  redirect target, valid while exc_take=1
- depth  out  4  current nesting level (0..NEST_DEPTH)
- nest_overflow  out  1  sticky overflow flag

Behaviour:
- Register map:
  - 12 Status: [0] IE; [1] EXL = (depth!=0), read-only; [15:8] IM, writable; all other bits read 0.
  - 13 Cause: [6:2] ExcCode; [15:8] IP, read-only. MTC0 to Cause is ignored.
  - 14 EPC: top-of-stack entry. MTC0 writes the top entry; at depth 0 it writes entry 0.
- rdata is combinational. Equals the addressed register when mfc0=1. Equals 0 when mfc0=0 or addr is unmapped.
- Reset values:
  - IE=0, IM=0, ExcCode=0, IP=0.
  - All EPC entries 0, depth=0, nest_overflow=0.
  - exc_take=0, exc_pc=0.
- IP sampling: IP register <= irq every cycle, so there is 1 cycle of sampling latency. Pending irqs are not latched; a deasserted irq drops its IP bit one cycle later.
- int_req = IE & |(IP & IM).
- Per-cycle event priority (highest first): exception > int_req > eret > mtc0. Lower events in the same cycle are dropped with no state change.
- Entry (exception, or int_req), when depth < NEST_DEPTH:
  - push pc and current IE; depth+1.
  - IE <= 0.
  - ExcCode <= cause for exception, 5'b00000 for interrupt.
- Entry when depth == NEST_DEPTH:
  - nest_overflow <= 1.
  - top EPC entry overwritten with pc; saved IE unchanged; depth unchanged.
  - IE <= 0; ExcCode updated.
- Entry output timing: next cycle exc_take=1 and exc_pc=EXC_VECTOR.
- ERET when depth > 0:
  - pop; IE <= saved IE; depth-1.
  - next cycle exc_take=1 and exc_pc = popped EPC.
- ERET when depth == 0:
  - exc_take=1 and exc_pc = entry 0.
  - IE and depth unchanged; no underflow.
- exc_take is high for exactly one cycle per accepted entry/ERET. Back-to-back events give back-to-back pulses.
- Entry suppresses int_req only through IE=0. A synchronous exception inside a handler nests normally.
- nest_overflow is cleared only by rst.
- rst asserted mid-operation: all state returns to reset values at that edge; a pending exc_take is cancelled.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined:
  - Adds Count (9) and Compare (11), both reset to 0.
  - Count increments every cycle, wraps at 2^32, and is writable by MTC0.
  - When Count == Compare (Compare != 0), timer-pending is set; it is held until an MTC0 to Compare clears it.
  - Timer-pending is ORed into IP[7] (Cause bit 15) in the same sampling stage as irq, so it is subject to IM[7] and IE.
- Not defined:
  - Addresses 9/11 read 0 and writes are ignored.
  - IP[7] comes only from irq (when NUM_IRQ=8, else 0).

Test Plan:
- Reset: rst=1 for 2 cycles, then MFC0 12/13/14 -> 0, 0, 0; depth=0, exc_take=0.
- Syscall: exception=1, cause=5'b01000, pc=32'h0040_0010 -> next cycle exc_take=1, exc_pc=32'h0000_4180; Cause=32'h20; EPC=32'h0040_0010; depth=1; IE=0.
- Interrupt: MTC0 Status=32'h0000_0101; irq[0] rises -> IP[0]=1 after 1 cycle, entry the following cycle; ExcCode=0; ERET -> exc_pc = saved pc, IE=1, depth=0.
- Nesting/overflow (NEST_DEPTH=4): 5 exceptions at pcs 0x100..0x140 step 0x10 -> depth 4, nest_overflow=1, EPC=0x140; 4 ERETs -> exc_pc 0x140, 0x120, 0x110, 0x100.
- Simultaneous: exception, eret and mtc0 in the same cycle -> only entry occurs; depth+1; written register unchanged.
- CP0_TIMER_EN: Compare=20, IM[7]=1, IE=1 -> interrupt entry with ExcCode 0; MTC0 Compare clears IP[7].
